// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a debug/host port.
// The CPU normally wins; a debug request that waits too long is forced ahead for one cycle.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Cpu_req,
  input  logic              Cpu_we,
  input  logic [ADDR_W-1:0] Cpu_addr,
  input  logic [DATA_W-1:0] Cpu_wdata,
  output logic              Cpu_stall,
  output logic [DATA_W-1:0] Cpu_rdata,
  output logic              Cpu_rvalid,
  input  logic              Dbg_req,
  input  logic              Dbg_we,
  input  logic [ADDR_W-1:0] Dbg_addr,
  input  logic [DATA_W-1:0] Dbg_wdata,
  output logic              Dbg_gnt,
  output logic [DATA_W-1:0] Dbg_rdata,
  output logic              Dbg_rvalid,
  output logic              Mem_en,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_wdata,
  input  logic [DATA_W-1:0] Mem_rdata,
  input  logic              Stall_clr,
  output logic [15:0]       Stall_cnt
);

  localparam logic [3:0] MaxWait = 4'(DBG_MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;
  logic        cpu_grant, dbg_grant;

  // Grants are gated by Rst_n so nothing reaches memory while reset is held.
  always_comb begin
    dbg_grant = Rst_n && Dbg_req && (!Cpu_req || (wait_cnt_q >= MaxWait));
    cpu_grant = Rst_n && Cpu_req && !dbg_grant;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!Dbg_req || dbg_grant) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall_clr) begin
      stall_cnt_d = 16'd0;
    end else if (Cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_comb begin
    cpu_rvalid_d = cpu_grant && !Cpu_we;
    dbg_rvalid_d = dbg_grant && !Dbg_we;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt_q   <= 4'd0;
      stall_cnt_q  <= 16'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  always_comb begin
    Mem_en    = 1'b0;
    Mem_we    = 1'b0;
    Mem_addr  = '0;
    Mem_wdata = '0;
    if (dbg_grant) begin
      Mem_en    = 1'b1;
      Mem_we    = Dbg_we;
      Mem_addr  = Dbg_addr;
      Mem_wdata = Dbg_wdata;
    end else if (cpu_grant) begin
      Mem_en    = 1'b1;
      Mem_we    = Cpu_we;
      Mem_addr  = Cpu_addr;
      Mem_wdata = Cpu_wdata;
    end
  end

  always_comb begin
    Cpu_stall  = Cpu_req && !cpu_grant;
    Dbg_gnt    = dbg_grant;
    Cpu_rdata  = Mem_rdata;
    Dbg_rdata  = Mem_rdata;
    Cpu_rvalid = cpu_rvalid_q;
    Dbg_rvalid = dbg_rvalid_q;
    Stall_cnt  = stall_cnt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Cpu_req, Cpu_we, Dbg_req, Dbg_we, Stall_clr;
  logic [7:0]  Cpu_addr, Cpu_wdata, Dbg_addr, Dbg_wdata;
  logic        Cpu_stall, Cpu_rvalid, Dbg_gnt, Dbg_rvalid, Mem_en, Mem_we;
  logic [7:0]  Cpu_rdata, Dbg_rdata, Mem_addr, Mem_wdata;
  logic [7:0]  Mem_rdata = 8'h00;
  logic [15:0] Stall_cnt;
  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .DBG_MAX_WAIT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Cpu_req(Cpu_req), .Cpu_we(Cpu_we), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
    .Cpu_stall(Cpu_stall), .Cpu_rdata(Cpu_rdata), .Cpu_rvalid(Cpu_rvalid),
    .Dbg_req(Dbg_req), .Dbg_we(Dbg_we), .Dbg_addr(Dbg_addr), .Dbg_wdata(Dbg_wdata),
    .Dbg_gnt(Dbg_gnt), .Dbg_rdata(Dbg_rdata), .Dbg_rvalid(Dbg_rvalid),
    .Mem_en(Mem_en), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Mem_rdata(Mem_rdata), .Stall_clr(Stall_clr), .Stall_cnt(Stall_cnt)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Mem_en && Mem_we) mem[Mem_addr] <= Mem_wdata;
    if (Mem_en && !Mem_we) Mem_rdata <= mem[Mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; Stall_clr = 1'b0;
    Cpu_req = 1'b0; Cpu_we = 1'b0; Cpu_addr = 8'h00; Cpu_wdata = 8'h00;
    Dbg_req = 1'b0; Dbg_we = 1'b0; Dbg_addr = 8'h00; Dbg_wdata = 8'h00;
    tick(); tick();

    // Reset state with both requesters active
    Cpu_req = 1'b1; Dbg_req = 1'b1;
    #1;
    chk("rst_mem_en", Mem_en, 1'b0);
    chk("rst_mem_we", Mem_we, 1'b0);
    chk("rst_dbg_gnt", Dbg_gnt, 1'b0);
    chk("rst_cpu_stall", Cpu_stall, 1'b1);
    tick();
    chk("rst_stall_cnt", Stall_cnt, 16'd0);
    chk("rst_cpu_rvalid", Cpu_rvalid, 1'b0);
    chk("rst_dbg_rvalid", Dbg_rvalid, 1'b0);
    Cpu_req = 1'b0; Dbg_req = 1'b0;
    tick();
    Rst_n = 1'b1;

    // CPU store then load
    Cpu_req = 1'b1; Cpu_we = 1'b1; Cpu_addr = 8'h37; Cpu_wdata = 8'h63;
    #1;
    chk("st_stall", Cpu_stall, 1'b0);
    chk("st_mem_en", Mem_en, 1'b1);
    chk("st_mem_we", Mem_we, 1'b1);
    chk("st_mem_addr", Mem_addr, 8'h37);
    chk("st_mem_wdata", Mem_wdata, 8'h63);
    tick();
    chk("st_no_rvalid", Cpu_rvalid, 1'b0);
    Cpu_we = 1'b0; Cpu_wdata = 8'h00;
    #1;
    chk("ld_stall", Cpu_stall, 1'b0);
    chk("ld_mem_we", Mem_we, 1'b0);
    tick();
    chk("ld_rvalid", Cpu_rvalid, 1'b1);
    chk("ld_rdata", Cpu_rdata, 8'h63);
    Cpu_req = 1'b0;
    #1;
    chk("idle_mem_en", Mem_en, 1'b0);
    chk("idle_mem_addr", Mem_addr, 8'h00);
    tick();
    chk("ld_rvalid_pulse", Cpu_rvalid, 1'b0);

    // Simultaneous request, wait count 0: CPU wins; debug then withdraws
    Cpu_req = 1'b1; Cpu_addr = 8'h37; Dbg_req = 1'b1; Dbg_we = 1'b1; Dbg_addr = 8'h10;
    #1;
    chk("sim_dbg_gnt", Dbg_gnt, 1'b0);
    chk("sim_cpu_stall", Cpu_stall, 1'b0);
    chk("sim_mem_addr", Mem_addr, 8'h37);
    tick();
    chk("sim_stall_cnt", Stall_cnt, 16'd0);
    Cpu_req = 1'b0; Dbg_req = 1'b0;
    #1;
    chk("drop_mem_en", Mem_en, 1'b0);
    tick();

    // Starvation bound: debug forced ahead in cycle 4
    Cpu_req = 1'b1; Cpu_addr = 8'h05; Dbg_we = 1'b0; Dbg_addr = 8'h06;
    for (int c = 0; c < 6; c++) begin
      Dbg_req = (c <= 4);
      #1;
      chk($sformatf("starve_gnt_c%0d", c), Dbg_gnt, (c == 4));
      chk($sformatf("starve_stall_c%0d", c), Cpu_stall, (c == 4));
      if (c == 5) chk("starve_dbg_rvalid", Dbg_rvalid, 1'b1);
      tick();
    end
    chk("starve_stall_cnt", Stall_cnt, 16'd1);
    Cpu_req = 1'b0;

    // Debug write, CPU reads it back
    Dbg_req = 1'b1; Dbg_we = 1'b1; Dbg_addr = 8'hC8; Dbg_wdata = 8'hDE;
    #1;
    chk("dwr_gnt", Dbg_gnt, 1'b1);
    chk("dwr_mem_we", Mem_we, 1'b1);
    chk("dwr_mem_addr", Mem_addr, 8'hC8);
    chk("dwr_mem_wdata", Mem_wdata, 8'hDE);
    tick();
    chk("dwr_no_rvalid", Dbg_rvalid, 1'b0);
    Dbg_req = 1'b0; Dbg_we = 1'b0; Dbg_wdata = 8'h00;
    Cpu_req = 1'b1; Cpu_we = 1'b0; Cpu_addr = 8'hC8;
    tick();
    chk("cld_rvalid", Cpu_rvalid, 1'b1);
    chk("cld_rdata", Cpu_rdata, 8'hDE);
    chk("cld_dbg_rvalid", Dbg_rvalid, 1'b0);
    Cpu_req = 1'b0;
    tick();

    // Saturation: preload near the top, then forced-debug stalls every fifth cycle
    force dut.stall_cnt_d = 16'hFFFE;
    tick();
    release dut.stall_cnt_d;
    #1;
    chk("sat_preload", Stall_cnt, 16'hFFFE);
    Cpu_req = 1'b1; Cpu_addr = 8'h37; Dbg_req = 1'b1; Dbg_addr = 8'hC8;
    for (int c = 0; c < 20; c++) begin
      if (c == 15) chk("sat_ffff", Stall_cnt, 16'hFFFF);
      if (c == 19) Stall_clr = 1'b1;
      #1;
      if (c == 19) chk("clr_stall", Cpu_stall, 1'b1);
      tick();
    end
    Stall_clr = 1'b0;
    chk("clr_cnt", Stall_cnt, 16'd0);
    Cpu_req = 1'b0; Dbg_req = 1'b0;
    tick();

    // Reset during a pending debug read
    Dbg_req = 1'b1; Dbg_we = 1'b0; Dbg_addr = 8'hC8;
    #1;
    chk("rrd_gnt", Dbg_gnt, 1'b1);
    tick();
    Dbg_req = 1'b0; Rst_n = 1'b0;
    #1;
    chk("rrd_rvalid_lost", Dbg_rvalid, 1'b0);
    Cpu_req = 1'b1; Dbg_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rrd_mem_en", Mem_en, 1'b0);
      chk("rrd_dbg_gnt", Dbg_gnt, 1'b0);
      chk("rrd_cpu_stall", Cpu_stall, 1'b1);
      tick();
      chk("rrd_dbg_rvalid", Dbg_rvalid, 1'b0);
      chk("rrd_stall_cnt", Stall_cnt, 16'd0);
    end
    Dbg_req = 1'b0; Cpu_addr = 8'h37;
    Rst_n = 1'b1;
    #1;
    chk("post_first_grant", Mem_en, 1'b1);
    chk("post_cpu_stall", Cpu_stall, 1'b0);
    tick();
    chk("post_dbg_rvalid", Dbg_rvalid, 1'b0);
    chk("post_cpu_rvalid", Cpu_rvalid, 1'b1);
    chk("post_cpu_rdata", Cpu_rdata, 8'h63);
    Cpu_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
